// File: rtl/s27_scan_pkg.sv
// Shared constants for the full-scan s27 benchmark.
package s27_scan_pkg;

  localparam int unsigned SCAN_LEN = 3;

  // Chain positions: scan_in -> G5 -> G6 -> G7 -> scan_out.
  localparam int unsigned IDX_G5 = 0;
  localparam int unsigned IDX_G6 = 1;
  localparam int unsigned IDX_G7 = 2;

endpackage

// File: rtl/s27_scan_dff.sv
// Mux-D scan cell: shift data when scan_en=1, capture d otherwise; sync active-low reset wins.
module s27_scan_dff
  import s27_scan_pkg::*;
(
  input  logic CK,
  input  logic rst_n,
  input  logic scan_en,
  input  logic d,
  input  logic si,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    if (scan_en) begin
      q_d = si;
    end else begin
      q_d = d;
    end
  end

  always_ff @(posedge CK) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/s27_scan.sv
// ISCAS-89 s27 with its three state flops replaced by a single stitched scan chain.
module s27_scan
  import s27_scan_pkg::*;
(
  input  logic CK,
  input  logic rst_n,
  input  logic scan_en,
  input  logic scan_in,
  input  logic G0,
  input  logic G1,
  input  logic G2,
  input  logic G3,
  output logic scan_out,
  output logic G17
);

  logic [SCAN_LEN-1:0] state_q;
  logic [SCAN_LEN-1:0] func_d;
  logic [SCAN_LEN-1:0] chain_si;

  logic g5_s, g6_s, g7_s;
  logic g8_s, g9_s, g10_s, g11_s, g12_s, g13_s, g14_s, g15_s, g16_s;

  assign g5_s = state_q[IDX_G5];
  assign g6_s = state_q[IDX_G6];
  assign g7_s = state_q[IDX_G7];

  always_comb begin
    g14_s = ~G0;
    g8_s  = g14_s & g6_s;
    g12_s = ~(G1 | g7_s);
    g15_s = g12_s | g8_s;
    g16_s = G3 | g8_s;
    g9_s  = ~(g16_s & g15_s);
    g11_s = ~(g5_s | g9_s);
    g10_s = ~(g14_s | g11_s);
    g13_s = ~(G2 | g12_s);
  end

  always_comb begin
    func_d[IDX_G5]   = g10_s;
    func_d[IDX_G6]   = g11_s;
    func_d[IDX_G7]   = g13_s;
    chain_si[IDX_G5] = scan_in;
    chain_si[IDX_G6] = g5_s;
    chain_si[IDX_G7] = g6_s;
  end

  for (genvar i = 0; i < SCAN_LEN; i++) begin : g_cell
    s27_scan_dff u_cell (
      .CK      (CK),
      .rst_n   (rst_n),
      .scan_en (scan_en),
      .d       (func_d[i]),
      .si      (chain_si[i]),
      .q       (state_q[i])
    );
  end

  // Output is deliberately ungated by scan_en, so it toggles during shift.
  assign G17      = ~g11_s;
  assign scan_out = g7_s;

endmodule

// File: tb/tb_s27_scan.sv
// Directed and pseudo-random checks of s27_scan against an independent s27 equation model.
module tb_s27_scan;

  logic CK = 1'b0;
  logic rst_n = 1'b1;
  logic scan_en = 1'b0;
  logic scan_in = 1'b0;
  logic G0 = 1'b0, G1 = 1'b0, G2 = 1'b0, G3 = 1'b0;
  logic scan_out, G17;

  int checks = 0;
  int errors = 0;

  s27_scan dut (
    .CK(CK), .rst_n(rst_n), .scan_en(scan_en), .scan_in(scan_in),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3),
    .scan_out(scan_out), .G17(G17)
  );

  always #5 CK = ~CK;

  // Golden s27: state is {G7,G6,G5}, inputs {G3,G2,G1,G0}.
  task automatic s27_model(input logic [3:0] g, input logic [2:0] st,
                           output logic g17, output logic [2:0] nx);
    logic a14, a8, a12, a15, a16, a9, a11, a10, a13;
    a14 = ~g[0];
    a8  = a14 & st[1];
    a12 = ~(g[1] | st[2]);
    a15 = a12 | a8;
    a16 = g[3] | a8;
    a9  = ~(a16 & a15);
    a11 = ~(st[0] | a9);
    a10 = ~(a14 | a11);
    a13 = ~(g[2] | a12);
    g17 = ~a11;
    nx  = {a13, a11, a10};
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic set_in(input logic [3:0] g);
    {G3, G2, G1, G0} = g;
  endtask

  function automatic logic [2:0] dut_state();
    return {dut.state_q[2], dut.state_q[1], dut.state_q[0]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    scan_en = 1'b0;
    set_in(4'b0000);
    do_reset();
    checks++;
    if (G17 !== 1'b1) begin errors++; $display("FAIL reset_g17 got %b want 1", G17); end
    checks++;
    if (scan_out !== 1'b0) begin errors++; $display("FAIL reset_scan_out got %b want 0", scan_out); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_state() !== 3'b000) begin
        errors++; $display("FAIL idle_state cyc %0d got %b want 000", i, dut_state());
      end
    end
  endtask

  task automatic test_g0_capture();
    do_reset();
    set_in(4'b0001);
    #1;
    checks++;
    if (G17 !== 1'b1) begin errors++; $display("FAIL g0_g17 got %b want 1", G17); end
    tick();
    checks++;
    if (dut_state() !== 3'b001) begin
      errors++; $display("FAIL g0_capture G7G6G5 got %b want 001", dut_state());
    end
  endtask

  task automatic test_g17_comb();
    set_in(4'b0000);
    do_reset();
    set_in(4'b1001);
    #1;
    checks++;
    if (G17 !== 1'b0) begin errors++; $display("FAIL g17_comb got %b want 0", G17); end
    set_in(4'b0000);
  endtask

  task automatic test_shift();
    logic [2:0] bits;
    logic [2:0] outs;
    bits = 3'b101;
    outs = 3'b010;
    do_reset();
    scan_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      scan_in = bits[i];
      tick();
    end
    checks++;
    if (dut_state() !== 3'b101) begin
      errors++; $display("FAIL shift_state G7G6G5 got %b want 101", dut_state());
    end
    checks++;
    if (scan_out !== 1'b1) begin errors++; $display("FAIL shift_scan_out got %b want 1", scan_out); end
    scan_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (scan_out !== outs[i]) begin
        errors++; $display("FAIL shift_out bit %0d got %b want %b", i, scan_out, outs[i]);
      end
    end
    scan_en = 1'b0;
  endtask

  task automatic test_load_capture();
    logic [2:0] load;
    logic [2:0] nx;
    logic g17_exp;
    load = 3'b011;
    do_reset();
    scan_en = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      scan_in = load[i];
      tick();
    end
    checks++;
    if (dut_state() !== load) begin
      errors++; $display("FAIL load_state got %b want %b", dut_state(), load);
    end
    scan_en = 1'b0;
    set_in(4'b0000);
    s27_model(4'b0000, load, g17_exp, nx);
    #1;
    checks++;
    if (G17 !== g17_exp) begin errors++; $display("FAIL load_g17 got %b want %b", G17, g17_exp); end
    tick();
    checks++;
    if (dut_state() !== nx) begin
      errors++; $display("FAIL capture_state got %b want %b", dut_state(), nx);
    end
    scan_en = 1'b1;
    scan_in = 1'b0;
    checks++;
    if (scan_out !== nx[2]) begin errors++; $display("FAIL unload bit2 got %b want %b", scan_out, nx[2]); end
    for (int i = 1; i >= 0; i--) begin
      tick();
      checks++;
      if (scan_out !== nx[i]) begin
        errors++; $display("FAIL unload bit%0d got %b want %b", i, scan_out, nx[i]);
      end
    end
    scan_en = 1'b0;
  endtask

  task automatic test_reset_priority();
    do_reset();
    scan_en = 1'b1;
    scan_in = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (dut_state() !== 3'b000) begin
      errors++; $display("FAIL rst_prio_state got %b want 000", dut_state());
    end
    checks++;
    if (scan_out !== 1'b0) begin errors++; $display("FAIL rst_prio_scan_out got %b want 0", scan_out); end
    rst_n = 1'b1;
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic test_random_equiv();
    logic [2:0] st;
    logic [2:0] nx;
    logic [3:0] g;
    logic g17_exp;
    int mism;
    mism = 0;
    scan_en = 1'b0;
    set_in(4'b0000);
    do_reset();
    st = 3'b000;
    for (int i = 0; i < 4000; i++) begin
      g = 4'($urandom_range(0, 15));
      set_in(g);
      #1;
      s27_model(g, st, g17_exp, nx);
      checks++;
      if (G17 !== g17_exp) begin
        errors++; mism++;
        if (mism <= 10) $display("FAIL equiv cyc %0d in %b st %b got %b want %b", i, g, st, G17, g17_exp);
      end
      tick();
      st = nx;
    end
  endtask

  initial begin
    test_reset();
    test_g0_capture();
    test_g17_comb();
    test_shift();
    test_load_capture();
    test_reset_priority();
    test_random_equiv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
